execute_muldiv: RTL and testbench

EXECUTE_MULDIV -- requirements
Module: execute_muldiv

---
 rtl/execute_muldiv.sv | 210 +++++++++++++++++++++
 tb/tb_execute_muldiv.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv.sv
// Execute stage: single-cycle ALU ops plus an iterative shift-add multiplier and
// restoring divider that stall upstream for WIDTH+1 cycles.
module execute_muldiv #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_ex_valid,
    input  logic [2:0]       id_ex_aluop,
    input  logic             id_ex_unsig,
    input  logic             id_ex_selimregb,
    input  logic [WIDTH-1:0] id_ex_rega,
    input  logic [WIDTH-1:0] id_ex_regb,
    input  logic [WIDTH-1:0] id_ex_imedext,
    input  logic             id_ex_readmem,
    input  logic             id_ex_writemem,
    input  logic             id_ex_selwsource,
    input  logic             id_ex_writereg,
    input  logic             id_ex_writeov,
    input  logic [REGW-1:0]  id_ex_regdest,
    input  logic             ex_flush,
    output logic             ex_if_stall,
    output logic             ex_mem_readmem,
    output logic             ex_mem_writemem,
    output logic             ex_mem_selwsource,
    output logic             ex_mem_writereg,
    output logic [REGW-1:0]  ex_mem_regdest,
    output logic [WIDTH-1:0] ex_mem_regb,
    output logic [WIDTH-1:0] ex_mem_wbvalue
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] work_hi, work_lo, operand_m;
    logic             op_div, op_unsig, res_neg, div_zero, div_ovf;

    logic [WIDTH-1:0] op_b, a_mag, b_mag, add_sum, sub_diff;
    logic             a_neg, b_neg, is_muldiv, accept, slt;
    logic [WIDTH-1:0] alu_value;
    logic             alu_ov;

    logic [WIDTH:0]     mul_sum, div_shift;
    logic [WIDTH-1:0]   div_sub, quotient, div_value;
    logic               div_ge, mul_ov, div_ov;
    logic [2*WIDTH-1:0] prod_mag, prod_signed;

    logic             complete, fin_ov;
    logic [WIDTH-1:0] fin_value;

    assign op_b      = id_ex_selimregb ? id_ex_imedext : id_ex_regb;
    assign is_muldiv = (id_ex_aluop[2:1] == 2'b11);
    assign accept    = (state == IDLE) && id_ex_valid && is_muldiv && !ex_flush;

    assign a_neg = !id_ex_unsig && id_ex_rega[WIDTH-1];
    assign b_neg = !id_ex_unsig && op_b[WIDTH-1];
    assign a_mag = a_neg ? -id_ex_rega : id_ex_rega;
    assign b_mag = b_neg ? -op_b : op_b;

    assign add_sum  = id_ex_rega + op_b;
    assign sub_diff = id_ex_rega - op_b;
    assign slt      = id_ex_unsig ? (id_ex_rega < op_b)
                                  : ($signed(id_ex_rega) < $signed(op_b));

    always_comb begin
        alu_value = '0;
        alu_ov    = 1'b0;
        case (id_ex_aluop)
            3'b000: begin
                alu_value = add_sum;
                alu_ov    = !id_ex_unsig && (id_ex_rega[WIDTH-1] == op_b[WIDTH-1])
                            && (add_sum[WIDTH-1] != id_ex_rega[WIDTH-1]);
            end
            3'b001: begin
                alu_value = sub_diff;
                alu_ov    = !id_ex_unsig && (id_ex_rega[WIDTH-1] != op_b[WIDTH-1])
                            && (sub_diff[WIDTH-1] != id_ex_rega[WIDTH-1]);
            end
            3'b010:  alu_value = id_ex_rega & op_b;
            3'b011:  alu_value = id_ex_rega | op_b;
            3'b100:  alu_value = id_ex_rega ^ op_b;
            3'b101:  alu_value = {{(WIDTH-1){1'b0}}, slt};
            default: alu_value = '0;
        endcase
    end

    // One iteration step: work_hi is the partial product / remainder, work_lo the
    // multiplier / dividend being shifted out while the quotient shifts in.
    assign mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, operand_m} : '0);
    assign div_shift = {work_hi, work_lo[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, operand_m});
    assign div_sub   = div_shift[WIDTH-1:0] - operand_m;

    assign prod_mag    = {work_hi, work_lo};
    assign prod_signed = res_neg ? -prod_mag : prod_mag;
    assign mul_ov      = op_unsig ? (|prod_signed[2*WIDTH-1:WIDTH])
                                  : (prod_signed[2*WIDTH-1:WIDTH] != {WIDTH{prod_signed[WIDTH-1]}});
    assign quotient    = res_neg ? -work_lo : work_lo;
    assign div_value   = div_zero ? '1 : quotient;
    assign div_ov      = div_zero || div_ovf;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (ex_flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_next = BUSY;
                BUSY:    if (count == CW'(1)) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        ex_if_stall = reset && (accept || ((state == BUSY) && !ex_flush));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            work_hi   <= '0;
            work_lo   <= '0;
            operand_m <= '0;
            op_div    <= 1'b0;
            op_unsig  <= 1'b0;
            res_neg   <= 1'b0;
            div_zero  <= 1'b0;
            div_ovf   <= 1'b0;
        end else if (ex_flush) begin
            count <= '0;
        end else if (accept) begin
            count     <= CW'(WIDTH);
            op_div    <= id_ex_aluop[0];
            op_unsig  <= id_ex_unsig;
            res_neg   <= a_neg ^ b_neg;
            div_zero  <= (op_b == '0);
            div_ovf   <= !id_ex_unsig && (id_ex_rega == MIN_VAL) && (op_b == '1);
            work_hi   <= '0;
            work_lo   <= id_ex_aluop[0] ? a_mag : b_mag;
            operand_m <= id_ex_aluop[0] ? b_mag : a_mag;
        end else if (state == BUSY) begin
            count <= count - CW'(1);
            if (op_div) begin
                work_hi <= div_ge ? div_sub : div_shift[WIDTH-1:0];
                work_lo <= {work_lo[WIDTH-2:0], div_ge};
            end else begin
                work_hi <= mul_sum[WIDTH:1];
                work_lo <= {mul_sum[0], work_lo[WIDTH-1:1]};
            end
        end
    end

    // Flush always wins; otherwise DONE or a valid single-cycle op writes the
    // pipeline register and everything else becomes a bubble.
    always_comb begin
        complete  = 1'b0;
        fin_value = alu_value;
        fin_ov    = alu_ov;
        if (ex_flush) begin
            complete = 1'b0;
        end else if (state == DONE) begin
            complete  = 1'b1;
            fin_value = op_div ? div_value : prod_signed[WIDTH-1:0];
            fin_ov    = op_div ? div_ov : mul_ov;
        end else if ((state == IDLE) && id_ex_valid && !is_muldiv) begin
            complete = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_mem_readmem    <= 1'b0;
            ex_mem_writemem   <= 1'b0;
            ex_mem_selwsource <= 1'b0;
            ex_mem_writereg   <= 1'b0;
            ex_mem_regdest    <= '0;
            ex_mem_regb       <= '0;
            ex_mem_wbvalue    <= '0;
        end else if (complete) begin
            ex_mem_readmem    <= id_ex_readmem;
            ex_mem_writemem   <= id_ex_writemem;
            ex_mem_selwsource <= id_ex_selwsource;
            ex_mem_writereg   <= id_ex_writereg && (!fin_ov || id_ex_writeov);
            ex_mem_regdest    <= id_ex_regdest;
            ex_mem_regb       <= id_ex_regb;
            ex_mem_wbvalue    <= fin_value;
        end else begin
            ex_mem_readmem    <= 1'b0;
            ex_mem_writemem   <= 1'b0;
            ex_mem_selwsource <= 1'b0;
            ex_mem_writereg   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_execute_muldiv.sv
// Scoreboard bench for execute_muldiv: a 32-bit instance for the full op set and
// an 8-bit instance for the short multiply latency.
module tb_execute_muldiv;

    logic        clock;
    logic        reset;
    logic        id_ex_valid, id_ex_unsig, id_ex_selimregb;
    logic [2:0]  id_ex_aluop;
    logic [31:0] id_ex_rega, id_ex_regb, id_ex_imedext;
    logic        id_ex_readmem, id_ex_writemem, id_ex_selwsource, id_ex_writereg, id_ex_writeov;
    logic [4:0]  id_ex_regdest;
    logic        ex_flush;
    logic        ex_if_stall;
    logic        ex_mem_readmem, ex_mem_writemem, ex_mem_selwsource, ex_mem_writereg;
    logic [4:0]  ex_mem_regdest;
    logic [31:0] ex_mem_regb, ex_mem_wbvalue;

    logic        v8, unsig8, sel8, rdm8, wrm8, sws8, wr8, wov8, flush8, stall8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, imm8;
    logic [4:0]  rd8;
    logic        o_rdm8, o_wrm8, o_sws8, o_wr8;
    logic [4:0]  o_rd8;
    logic [7:0]  o_rb8, o_wb8;

    typedef struct {
        string       tag;
        logic [31:0] wb;
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] rb;
        logic        sws;
        int          stalls;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          next_rd = 1;
    logic [31:0] last_wb = '0;

    execute_muldiv #(.WIDTH(32), .REGW(5)) u_dut (
        .clock(clock), .reset(reset),
        .id_ex_valid(id_ex_valid), .id_ex_aluop(id_ex_aluop), .id_ex_unsig(id_ex_unsig),
        .id_ex_selimregb(id_ex_selimregb), .id_ex_rega(id_ex_rega), .id_ex_regb(id_ex_regb),
        .id_ex_imedext(id_ex_imedext), .id_ex_readmem(id_ex_readmem),
        .id_ex_writemem(id_ex_writemem), .id_ex_selwsource(id_ex_selwsource),
        .id_ex_writereg(id_ex_writereg), .id_ex_writeov(id_ex_writeov),
        .id_ex_regdest(id_ex_regdest), .ex_flush(ex_flush), .ex_if_stall(ex_if_stall),
        .ex_mem_readmem(ex_mem_readmem), .ex_mem_writemem(ex_mem_writemem),
        .ex_mem_selwsource(ex_mem_selwsource), .ex_mem_writereg(ex_mem_writereg),
        .ex_mem_regdest(ex_mem_regdest), .ex_mem_regb(ex_mem_regb),
        .ex_mem_wbvalue(ex_mem_wbvalue)
    );

    execute_muldiv #(.WIDTH(8), .REGW(5)) u_dut8 (
        .clock(clock), .reset(reset),
        .id_ex_valid(v8), .id_ex_aluop(op8), .id_ex_unsig(unsig8),
        .id_ex_selimregb(sel8), .id_ex_rega(a8), .id_ex_regb(b8),
        .id_ex_imedext(imm8), .id_ex_readmem(rdm8),
        .id_ex_writemem(wrm8), .id_ex_selwsource(sws8),
        .id_ex_writereg(wr8), .id_ex_writeov(wov8),
        .id_ex_regdest(rd8), .ex_flush(flush8), .ex_if_stall(stall8),
        .ex_mem_readmem(o_rdm8), .ex_mem_writemem(o_wrm8),
        .ex_mem_selwsource(o_sws8), .ex_mem_writereg(o_wr8),
        .ex_mem_regdest(o_rd8), .ex_mem_regb(o_rb8),
        .ex_mem_wbvalue(o_wb8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Reference model in 64-bit arithmetic; returns {ov, value}.
    function automatic logic [32:0] model(input logic [2:0] op, input logic uns,
                                          input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, r;
        longint unsigned ua, ub, ur;
        logic [31:0]     v;
        logic            ov;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        v  = '0;
        ov = 1'b0;
        case (op)
            3'd0: begin r = sa + sb; v = a + b; ov = !uns && (r > 64'sd2147483647 || r < -64'sd2147483648); end
            3'd1: begin r = sa - sb; v = a - b; ov = !uns && (r > 64'sd2147483647 || r < -64'sd2147483648); end
            3'd2: v = a & b;
            3'd3: v = a | b;
            3'd4: v = a ^ b;
            3'd5: v = {31'b0, uns ? (ua < ub) : (sa < sb)};
            3'd6: begin
                if (uns) begin
                    ur = ua * ub; v = ur[31:0]; ov = (ur >> 32) != 0;
                end else begin
                    r = sa * sb; v = r[31:0]; ov = (r > 64'sd2147483647 || r < -64'sd2147483648);
                end
            end
            default: begin
                if (b == 32'b0) begin
                    v = '1; ov = 1'b1;
                end else if (uns) begin
                    ur = ua / ub; v = ur[31:0];
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    v = 32'h8000_0000; ov = 1'b1;
                end else begin
                    r = sa / sb; v = r[31:0];
                end
            end
        endcase
        return {ov, v};
    endfunction

    task automatic driveInputs(input logic [2:0] op, input logic uns, input logic [31:0] a,
                               input logic [31:0] b, input logic sel, input logic wr, input logic wov);
        id_ex_valid      = 1'b1;
        id_ex_aluop      = op;
        id_ex_unsig      = uns;
        id_ex_rega       = a;
        id_ex_selimregb  = sel;
        id_ex_imedext    = sel ? b : 32'h1234_5678;
        id_ex_regb       = sel ? (32'hA5A5_0000 ^ 32'(next_rd)) : b;
        id_ex_writereg   = wr;
        id_ex_writeov    = wov;
        id_ex_regdest    = 5'(next_rd);
        id_ex_selwsource = next_rd[0];
        id_ex_readmem    = 1'b0;
        id_ex_writemem   = 1'b0;
    endtask

    // Called at a falling edge; pushes the expectation, waits out any stall and
    // compares the registered result one edge after the stall drops.
    task automatic applyStimulus(input string tag, input logic [2:0] op, input logic uns,
                                 input logic [31:0] a, input logic [31:0] b, input logic sel,
                                 input logic wr, input logic wov,
                                 input logic [31:0] exp_wb, input logic exp_wr);
        exp_t e;
        int   n;
        e.tag    = tag;
        e.wb     = exp_wb;
        e.wr     = exp_wr;
        e.rd     = 5'(next_rd);
        e.rb     = sel ? (32'hA5A5_0000 ^ 32'(next_rd)) : b;
        e.sws    = next_rd[0];
        e.stalls = (op[2:1] == 2'b11) ? 33 : 0;
        sb_q.push_back(e);
        driveInputs(op, uns, a, b, sel, wr, wov);
        #1;
        n = 0;
        while (ex_if_stall && n < 100) begin
            n++;
            @(negedge clock);
            #1;
        end
        @(negedge clock);
        id_ex_valid = 1'b0;
        e = sb_q.pop_front();
        checkOutput({e.tag, "_stalls"}, 64'(n), 64'(e.stalls));
        checkOutput({e.tag, "_wb"}, {32'b0, ex_mem_wbvalue}, {32'b0, e.wb});
        checkOutput({e.tag, "_wr"}, {63'b0, ex_mem_writereg}, {63'b0, e.wr});
        checkOutput({e.tag, "_rd"}, {59'b0, ex_mem_regdest}, {59'b0, e.rd});
        checkOutput({e.tag, "_rb"}, {32'b0, ex_mem_regb}, {32'b0, e.rb});
        checkOutput({e.tag, "_sws"}, {63'b0, ex_mem_selwsource}, {63'b0, e.sws});
        last_wb = e.wb;
        next_rd = (next_rd % 31) + 1;
    endtask

    initial begin
        int          n;
        int          k;
        logic        saw_write;
        logic [2:0]  rop;
        logic        runs, rsel, rwov;
        logic [31:0] ra, rbv;
        logic [32:0] m;

        reset = 1'b0;
        ex_flush = 1'b0;
        driveInputs(3'b110, 1'b0, 32'd5, 32'd9, 1'b0, 1'b1, 1'b0);
        v8 = 1'b0; op8 = 3'b110; unsig8 = 1'b0; sel8 = 1'b0; a8 = 8'hFD; b8 = 8'h07;
        imm8 = 8'h00; rdm8 = 1'b0; wrm8 = 1'b0; sws8 = 1'b0; wr8 = 1'b1; wov8 = 1'b0;
        rd8 = 5'd3; flush8 = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("rst_stall", {63'b0, ex_if_stall}, 64'd0);
        checkOutput("rst_wb", {32'b0, ex_mem_wbvalue}, 64'd0);
        checkOutput("rst_wr", {63'b0, ex_mem_writereg}, 64'd0);
        id_ex_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);

        applyStimulus("add_ovf", 3'b000, 1'b0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 1'b0);
        applyStimulus("add_uns", 3'b000, 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 1'b1);
        applyStimulus("sub_ovf", 3'b001, 1'b0, 32'h8000_0000, 32'h1, 1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b0);
        applyStimulus("and_imm", 3'b010, 1'b0, 32'hF0F0_FFFF, 32'h0FF0_00F0, 1'b1, 1'b1, 1'b0, 32'h00F0_00F0, 1'b1);
        applyStimulus("or", 3'b011, 1'b0, 32'hF000_0001, 32'h0000_0F00, 1'b0, 1'b1, 1'b0, 32'hF000_0F01, 1'b1);
        applyStimulus("xor", 3'b100, 1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0, 1'b1, 1'b0, 32'hF0F0_0F0F, 1'b1);
        applyStimulus("slt_s", 3'b101, 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0, 32'h1, 1'b1);
        applyStimulus("slt_u", 3'b101, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

        applyStimulus("mul_neg", 3'b110, 1'b0, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFEB, 1'b1);
        applyStimulus("add_after", 3'b000, 1'b0, 32'd5, 32'd6, 1'b0, 1'b1, 1'b0, 32'd11, 1'b1);
        @(negedge clock);
        checkOutput("bubble_wr", {63'b0, ex_mem_writereg}, 64'd0);
        checkOutput("bubble_hold", {32'b0, ex_mem_wbvalue}, {32'b0, last_wb});
        applyStimulus("mul_u_ovf", 3'b110, 1'b1, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus("div_zero", 3'b111, 1'b0, 32'd7, 32'd0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
        applyStimulus("div_minm1", 3'b111, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 1'b1);
        applyStimulus("div_neg", 3'b111, 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFD, 1'b1);
        applyStimulus("div_uns", 3'b111, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 1'b0, 32'h7FFF_FFFC, 1'b1);

        for (int i = 0; i < 10; i++) begin
            rop  = 3'($urandom_range(0, 7));
            runs = 1'($urandom_range(0, 1));
            rsel = 1'($urandom_range(0, 1));
            rwov = 1'($urandom_range(0, 1));
            ra   = $urandom;
            rbv  = $urandom >> $urandom_range(0, 28);
            m    = model(rop, runs, ra, rbv);
            applyStimulus("rand", rop, runs, ra, rbv, rsel, 1'b1, rwov, m[31:0], !m[32] || rwov);
        end

        // Kill a multiply partway through BUSY.
        driveInputs(3'b110, 1'b0, 32'd100, 32'd100, 1'b0, 1'b1, 1'b0);
        #1;
        n = 0;
        k = 0;
        while (n < 10 && k < 50) begin
            if (ex_if_stall) n++;
            k++;
            @(negedge clock);
            #1;
        end
        ex_flush = 1'b1;
        #1;
        checkOutput("flush_stall", {63'b0, ex_if_stall}, 64'd0);
        @(negedge clock);
        checkOutput("flush_wr", {63'b0, ex_mem_writereg}, 64'd0);
        checkOutput("flush_hold", {32'b0, ex_mem_wbvalue}, {32'b0, last_wb});
        ex_flush = 1'b0;
        id_ex_valid = 1'b0;
        saw_write = 1'b0;
        repeat (40) begin
            @(negedge clock);
            saw_write = saw_write | ex_mem_writereg;
        end
        checkOutput("flush_nowb", {63'b0, saw_write}, 64'd0);
        applyStimulus("mul_postflush", 3'b110, 1'b0, 32'd1000, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 32'hFFFF_F830, 1'b1);

        // Reset mid-BUSY must discard the operation.
        driveInputs(3'b111, 1'b0, 32'd1000, 32'd10, 1'b0, 1'b1, 1'b0);
        #1;
        n = 0;
        k = 0;
        while (n < 5 && k < 50) begin
            if (ex_if_stall) n++;
            k++;
            @(negedge clock);
            #1;
        end
        reset = 1'b0;
        #1;
        checkOutput("rstb_stall", {63'b0, ex_if_stall}, 64'd0);
        checkOutput("rstb_wb", {32'b0, ex_mem_wbvalue}, 64'd0);
        checkOutput("rstb_wr", {63'b0, ex_mem_writereg}, 64'd0);
        checkOutput("rstb_rd", {59'b0, ex_mem_regdest}, 64'd0);
        checkOutput("rstb_rb", {32'b0, ex_mem_regb}, 64'd0);
        id_ex_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        saw_write = 1'b0;
        repeat (40) begin
            @(negedge clock);
            saw_write = saw_write | ex_mem_writereg;
        end
        checkOutput("rstb_nowb", {63'b0, saw_write}, 64'd0);
        applyStimulus("add_postrst", 3'b000, 1'b0, 32'd40, 32'd2, 1'b0, 1'b1, 1'b0, 32'd42, 1'b1);

        // Narrow build: same multiply, shorter latency.
        v8 = 1'b1;
        #1;
        n = 0;
        while (stall8 && n < 50) begin
            n++;
            @(negedge clock);
            #1;
        end
        @(negedge clock);
        v8 = 1'b0;
        checkOutput("w8_stalls", 64'(n), 64'd9);
        checkOutput("w8_wb", {56'b0, o_wb8}, 64'h00EB);
        checkOutput("w8_wr", {63'b0, o_wr8}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
